// File: rtl/if_stage.sv
// ============================================================================
// if_stage -- instruction fetch stage with IF/ID pipeline register.
//
// Holds the PC, issues one fetch per cycle to a same-cycle-response
// instruction memory and captures the returned word into the IF/ID register.
// A three-state FSM (BOOT, FETCH, MISS) sequences start-up and miss retry.
// Per-edge priority: flush, then stall, then miss, then normal fetch.
//
// Optional feature: define IF_PERF_CNT_EN to build the saturating
// performance counters. Without it the counter outputs are tied to zero and
// no counter flops exist.
//
// Ports
//   clk_50      in   1   clock, rising edge
//   rst_i       in   1   asynchronous active-low reset
//   stall       in   1   load-use stall from ID: hold PC and IF/ID
//   flush       in   1   taken branch/jump: redirect PC, squash IF/ID
//   br_target   in  32   redirect address, low two bits forced to zero
//   imem_req    out  1   fetch request valid (0 only in BOOT)
//   imem_addr   out 32   fetch address (the PC register)
//   imem_rdata  in  32   instruction word for imem_addr when imem_hit=1
//   imem_hit    in   1   same-cycle response, 0 = miss, retry next cycle
//   INST        out 32   IF/ID instruction
//   PC_ID       out 32   PC of INST
//   if_valid    out  1   INST is a real fetched instruction
//   fetch_cnt   out 32   accepted fetches        (IF_PERF_CNT_EN)
//   stall_cnt   out 32   cycles stalled          (IF_PERF_CNT_EN)
//   flush_cnt   out 32   cycles flushed          (IF_PERF_CNT_EN)
// ============================================================================
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk_50,
   input  logic        rst_i,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] br_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_hit,
   output logic [31:0] INST,
   output logic [31:0] PC_ID,
   output logic        if_valid,
   output logic [31:0] fetch_cnt,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
);

   typedef enum logic [1:0] {BOOT, FETCH, MISS} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] pcid_q, pcid_d;
   logic        valid_q, valid_d;

   assign imem_req  = (state_q != BOOT);
   assign imem_addr = pc_q;
   assign INST      = inst_q;
   assign PC_ID     = pcid_q;
   assign if_valid  = valid_q;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      pcid_d  = pcid_q;
      valid_d = valid_q;
      if (flush) begin
         // Redirect wins over everything; stall and imem_hit are ignored.
         state_d = FETCH;
         pc_d    = {br_target[31:2], 2'b00};
         inst_d  = NOP_INST;
         valid_d = 1'b0;
      end else if (state_q == BOOT) begin
         // No request issued this cycle, so IF/ID can only take a bubble.
         state_d = FETCH;
         inst_d  = NOP_INST;
         valid_d = 1'b0;
      end else begin
         state_d = imem_hit ? FETCH : MISS;
         // Under stall the IF/ID register and PC hold; a hit arriving in
         // that cycle is dropped and the same PC is refetched later.
         if (!stall) begin
            if (!imem_hit) begin
               inst_d  = NOP_INST;
               valid_d = 1'b0;
            end else begin
               inst_d  = imem_rdata;
               pcid_d  = pc_q;
               valid_d = 1'b1;
               pc_d    = pc_q + 32'd4;   // wraps FFFF_FFFC -> 0
            end
         end
      end
   end

   always_ff @(posedge clk_50 or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         inst_q  <= NOP_INST;
         pcid_q  <= 32'd0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         pcid_q  <= pcid_d;
         valid_q <= valid_d;
      end
   end

`ifdef IF_PERF_CNT_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   logic        fetch_hit;
   logic [31:0] fetch_cnt_q, stall_cnt_q, flush_cnt_q;

   // Same condition under which IF/ID captures imem_rdata.
   assign fetch_hit = !flush && !stall && (state_q != BOOT) && imem_hit;

   always_ff @(posedge clk_50 or negedge rst_i) begin
      if (!rst_i) begin
         fetch_cnt_q <= 32'd0;
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         if (fetch_hit)       fetch_cnt_q <= sat_inc(fetch_cnt_q);
         if (stall && !flush) stall_cnt_q <= sat_inc(stall_cnt_q);
         if (flush)           flush_cnt_q <= sat_inc(flush_cnt_q);
      end
   end

   assign fetch_cnt = fetch_cnt_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign fetch_cnt = 32'd0;
   assign stall_cnt = 32'd0;
   assign flush_cnt = 32'd0;
`endif

endmodule
